// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter between the I-cache and D-cache miss paths.
// Data side wins ties; a starvation counter forces an I grant after STARVE_LIM data wins.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_LIM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        mem_stall,
  input  logic [15:0] mem_data_out,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        i_done,
  output logic [15:0] i_data_out,
  output logic        i_stall,
  output logic        d_done,
  output logic [15:0] d_data_out,
  output logic        d_stall,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

  arbState    state;
  logic       ownerD;
  logic       wrFlag;
  logic [2:0] latCnt;
  logic [2:0] starveCnt;
  logic       grantI;

  assign grantI  = i_req && (!d_req || starveCnt == STARVE_MAX);
  assign busy    = (state != IDLE);
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  // The memory-side address/data registers double as the latched request:
  // they are loaded at grant, held through stalls and cleared on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ownerD      <= 1'b0;
      wrFlag      <= 1'b0;
      latCnt      <= '0;
      starveCnt   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_data_out  <= '0;
      d_data_out  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch
      // reads the pre-edge values; the done pulses default low each cycle.
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state  <= ISSUE;
            ownerD <= !grantI;
            if (grantI) begin
              wrFlag      <= 1'b0;
              mem_rd      <= 1'b1;
              mem_wr      <= 1'b0;
              mem_addr    <= i_addr;
              mem_data_in <= '0;
              starveCnt   <= '0;
            end else begin
              wrFlag      <= d_wr;
              mem_rd      <= !d_wr;
              mem_wr      <= d_wr;
              mem_addr    <= d_addr;
              mem_data_in <= d_data_in;
              if (i_req && starveCnt < STARVE_MAX) starveCnt <= starveCnt + 3'd1;
            end
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            latCnt      <= LAT_LOAD;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A zero count marks the capture cycle, which also covers MEM_LAT == 1.
          if (latCnt == '0) begin
            if (!wrFlag) begin
              if (ownerD) d_data_out <= mem_data_out;
              else        i_data_out <= mem_data_out;
            end
            if (ownerD) d_done <= 1'b1;
            else        i_done <= 1'b1;
            state <= RESP;
          end else begin
            latCnt <= latCnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between the instruction-cache miss path and the data-cache miss path for the single shared main memory port.
- Sits between the two cache controllers and the banked main memory.
- Grants one requester at a time, issues one access, counts the fixed memory latency, then returns read data with a one-cycle done pulse.
- Data side has priority; an anti-starvation counter guarantees forward progress for instruction fetch.

Parameters:
MEM_LAT, 4, cycles from accepted issue to mem_data_out valid; legal range 1..8
STARVE_LIM, 2, consecutive D grants made while i_req was pending before I is forced to win; legal range 1..7

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_req  in  1  instruction-side request; level, held until i_done
i_addr  in  16  instruction-side address
d_req  in  1  data-side request; level, held until d_done
d_wr  in  1  data-side write (1) / read (0)
d_addr  in  16  data-side address
d_data_in  in  16  data-side write data
mem_stall  in  1  memory cannot accept an issue this cycle
mem_data_out  in  16  memory read data
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  16  memory address
mem_data_in  out  16  memory write data
i_done  out  1  one-cycle completion pulse, I side
i_data_out  out  16  I-side read data; valid when i_done, held until next I capture
i_stall  out  1  i_req & ~i_done
d_done  out  1  one-cycle completion pulse, D side
d_data_out  out  16  D-side read data; valid when d_done, held until next D capture
d_stall  out  1  d_req & ~d_done
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, including i_data_out and d_data_out.
  - Latency counter = 0; starvation counter = 0.
- Reset mid-transaction: the in-flight access is abandoned; no done pulse is generated.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration on registered state:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both requesting: grant D, unless starvation counter == STARVE_LIM, in which case grant I.
- On grant:
  - Latch the owner, the address, the write flag (I side always reads) and the write data.
  - Go to ISSUE.
- Starvation counter:
  - +1 on each D grant made while i_req = 1; saturates at STARVE_LIM.
  - Cleared on any I grant.
- ISSUE:
  - mem_rd or mem_wr = 1; mem_addr and mem_data_in driven from the latched values.
  - mem_stall = 1: stay in ISSUE and re-drive the same access.
  - mem_stall = 0: access accepted (call this cycle t); latency counter loaded with MEM_LAT-1.
    - If MEM_LAT == 1: go straight to the capture cycle, i.e. capture in t+1.
    - Otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In cycle t+MEM_LAT, mem_data_out is captured into the owner's data_out register (reads only; writes leave it unchanged) and the state moves to RESP.
- RESP (cycle t+MEM_LAT+1):
  - Owner's done = 1 for exactly one cycle.
  - Go to IDLE.
- Outside ISSUE: mem_rd, mem_wr, mem_addr and mem_data_in are 0.
- Timing, no stall, MEM_LAT = 4:
  - Request first seen in IDLE at cycle 0.
  - Issue in cycle 1, capture in cycle 5, done in cycle 6.
  - Next arbitration in cycle 7.
- A new request is never granted while busy. A requester that raised its request during another's transaction is arbitrated in the first IDLE cycle afterwards.
- Requester deasserts req mid-transaction: the transaction still completes and done still pulses.
- Simultaneous done and re-request from the same requester: the re-request is treated as a new request in the next IDLE cycle.
- Write transactions follow the identical timing; done signals that the write is committed.
- Address and data inputs are sampled only at grant; changes afterwards are ignored.

Test Plan:
- Single I read, MEM_LAT=4, i_addr=0x0040, mem_data_out=0xBEEF during cycle 5 -> mem_rd=1 with mem_addr=0x0040 in cycle 1; i_done=1 and i_data_out=0xBEEF in cycle 6 only; busy low in cycle 7.
- D write d_addr=0x1000, d_data_in=0x1234 with mem_stall=1 for 2 cycles -> mem_wr held with mem_addr=0x1000 and mem_data_in=0x1234 for 3 cycles; d_done 5 cycles after the first unstalled issue cycle; d_data_out unchanged.
- i_req and d_req asserted together and held, each re-requesting immediately after done, STARVE_LIM=2 -> grant order D, D, I, D, D, I; i_stall stays 1 until its done.
- d_req arrives while an I transaction is in WAIT -> no second issue until the I transaction finishes; D issued in the second cycle after i_done.
- rst asserted during WAIT of a D read -> next cycle all outputs 0, busy=0, no d_done; held req re-granted after rst drops.
- MEM_LAT=1 with read data 0x00FF -> done exactly 2 cycles after the accepted issue, carrying 0x00FF.
